// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fifo_arb_pkg
// Brief    : Shared state encoding and width helper for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Burst counter width; a single-word burst still needs one bit.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker with start index and exclude mask.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  input  logic [NREQ-1:0] excl,
  output logic [NREQ-1:0] win,
  output logic            found
);

  logic [NREQ-1:0] w_cand;

  assign w_cand = req & ~excl;

  always_comb begin
    int            w_pos;
    logic [IW-1:0] w_sel;
    w_pos = 0;
    w_sel = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(start) + k;
      if (w_pos >= NREQ) w_pos = w_pos - NREQ;
      w_sel = IW'(w_pos);
      if (!found && w_cand[w_sel]) begin
        win[w_sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter sharing the async_fifo write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int BURST = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_srst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_wr_en,
  output logic [WIDTH-1:0]      fifo_wr_data,
  input  logic                  fifo_wr_full,
  output logic [NREQ-1:0]       grant
);

  localparam int c_idx_w = $clog2(NREQ);
  localparam int c_cnt_w = cnt_width(BURST);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BURST - 1);

  state_t             r_state, w_state_nxt;
  logic [NREQ-1:0]    r_grant, w_grant_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0] r_ptr, w_ptr_nxt;
  logic [c_idx_w-1:0] w_owner, w_ptr_rel, w_start;
  logic [NREQ-1:0]    w_excl, w_win;
  logic               w_found, w_own, w_owner_valid, w_xfer, w_release;

  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant[i]) w_owner = c_idx_w'(i);
    end
  end

  assign w_own         = (r_state == OWN);
  assign w_owner_valid = |(req_valid & r_grant);
  assign w_xfer        = w_own & w_owner_valid & ~fifo_wr_full;
  assign w_release     = w_own & (~w_owner_valid | (w_xfer & (r_cnt == c_cnt_last)));
  assign w_ptr_rel     = (w_owner == c_idx_w'(NREQ - 1)) ? '0 : w_owner + 1'b1;
  assign w_start       = w_own ? w_ptr_rel : r_ptr;
  // The outgoing owner only wins again when nobody else is asking.
  assign w_excl        = (w_own && |(req_valid & ~r_grant)) ? r_grant : '0;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (c_idx_w)
  ) u_rr_pick (
    .req   (req_valid),
    .start (w_start),
    .excl  (w_excl),
    .win   (w_win),
    .found (w_found)
  );

  always_ff @(posedge wr_clk) begin
    if (wr_srst) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_cnt   <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_cnt_nxt   = r_cnt;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = OWN;
          w_grant_nxt = w_win;
          w_cnt_nxt   = '0;
        end
      end
      OWN: begin
        if (w_release) begin
          w_ptr_nxt   = w_ptr_rel;
          w_cnt_nxt   = '0;
          w_state_nxt = w_found ? OWN : IDLE;
          w_grant_nxt = w_found ? w_win : '0;
        end else if (w_xfer) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  always_comb begin
    req_ready    = (w_own && !fifo_wr_full) ? r_grant : '0;
    fifo_wr_en   = w_xfer;
    fifo_wr_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_own && r_grant[i]) fifo_wr_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  assign grant = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Self-checking bench: vector table, burst-1 sequence, full test, random.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int B = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   v;
  logic [N*W-1:0] d;
  logic           full;
  logic [N-1:0]   ready, grant;
  logic           en;
  logic [W-1:0]   wdata;

  logic           rst1;
  logic [N-1:0]   v1;
  logic           full1;
  logic [N-1:0]   ready1, grant1;
  logic           en1;
  logic [W-1:0]   wdata1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(B)) u_dut (
    .wr_clk       (clk),
    .wr_srst      (rst),
    .req_valid    (v),
    .req_data     (d),
    .req_ready    (ready),
    .fifo_wr_en   (en),
    .fifo_wr_data (wdata),
    .fifo_wr_full (full),
    .grant        (grant)
  );

  fifo_wr_arbiter #(.WIDTH(W), .NREQ(N), .BURST(1)) u_dut1 (
    .wr_clk       (clk),
    .wr_srst      (rst1),
    .req_valid    (v1),
    .req_data     (d),
    .req_ready    (ready1),
    .fifo_wr_en   (en1),
    .fifo_wr_data (wdata1),
    .fifo_wr_full (full1),
    .grant        (grant1)
  );

  typedef struct {
    logic       ri;
    logic [3:0] vi;
    logic       fi;
    logic [3:0] eg;
    logic [3:0] er;
    logic       een;
    logic [7:0] ed;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic ri, input logic [3:0] vi, input logic fi,
                     input logic [3:0] eg, input logic een, input logic [7:0] ed);
    vec_t e;
    e.ri = ri; e.vi = vi; e.fi = fi;
    e.eg = eg; e.er = fi ? 4'b0000 : eg; e.een = een; e.ed = ed;
    tv.push_back(e);
  endtask

  // Reference model: owner index (-1 idle), words sent in this grant, pointer.
  int m_own, m_cnt, m_ptr;

  function automatic int pick(input logic [N-1:0] vv, input int from, input int skip);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (vv[idx] && idx != skip) return idx;
    end
    return -1;
  endfunction

  task automatic model_edge();
    int  nxt;
    logic xfer;
    if (rst) begin
      m_own = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_own < 0) begin
      m_own = pick(v, m_ptr, -1);
      m_cnt = 0;
    end else begin
      xfer = v[m_own] && !full;
      if (!v[m_own] || (xfer && m_cnt == B - 1)) begin
        m_ptr = (m_own + 1) % N;
        nxt = pick(v, m_ptr, m_own);
        if (nxt < 0 && v[m_own]) nxt = m_own;
        m_own = nxt;
        m_cnt = 0;
      end else if (xfer) begin
        m_cnt++;
      end
    end
  endtask

  logic [3:0] b1_v [12] = '{4'h0, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h3, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
  logic [3:0] b1_g [12] = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1};
  logic       b1_e [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    logic [7:0]   q[$];
    logic [7:0]   popped, exp_d;
    logic [N-1:0] s_rdy, exp_g, exp_r, acc;
    logic         s_en, exp_en;
    int           idx, got;

    rst = 1'b1; v = 4'hF; full = 1'b0; d = 32'h33221100;
    rst1 = 1'b1; v1 = 4'h0; full1 = 1'b0;
    @(posedge clk); #1;

    // rst, valid, full, grant, wr_en, wr_data
    add(1, 4'hF, 0, 4'h0, 0, 8'h00);
    add(1, 4'hF, 0, 4'h0, 0, 8'h00);
    add(1, 4'hF, 0, 4'h0, 0, 8'h00);
    add(0, 4'hF, 0, 4'h0, 0, 8'h00);
    for (int i = 0; i < 4; i++) add(0, 4'hF, 0, 4'h1, 1, 8'h00);
    for (int i = 0; i < 4; i++) add(0, 4'hF, 0, 4'h2, 1, 8'h11);
    add(0, 4'hF, 1, 4'h4, 0, 8'h22);
    add(0, 4'hF, 1, 4'h4, 0, 8'h22);
    for (int i = 0; i < 3; i++) add(0, 4'hF, 0, 4'h4, 1, 8'h22);
    add(0, 4'hF, 1, 4'h4, 0, 8'h22);
    add(0, 4'hF, 0, 4'h4, 1, 8'h22);
    add(0, 4'hA, 0, 4'h8, 1, 8'h33);
    add(0, 4'h2, 0, 4'h8, 0, 8'h33);
    add(0, 4'h2, 0, 4'h2, 1, 8'h11);
    add(0, 4'hA, 0, 4'h2, 1, 8'h11);
    add(0, 4'h8, 0, 4'h2, 0, 8'h11);
    add(0, 4'h8, 0, 4'h8, 1, 8'h33);
    add(0, 4'h0, 0, 4'h8, 0, 8'h33);
    add(0, 4'h0, 0, 4'h0, 0, 8'h00);
    add(0, 4'h4, 0, 4'h0, 0, 8'h00);
    add(0, 4'h4, 0, 4'h4, 1, 8'h22);
    add(1, 4'h4, 0, 4'h4, 1, 8'h22);
    add(0, 4'hF, 0, 4'h0, 0, 8'h00);
    add(0, 4'hF, 0, 4'h1, 1, 8'h00);

    foreach (tv[i]) begin
      rst = tv[i].ri; v = tv[i].vi; full = tv[i].fi;
      @(negedge clk);
      chk($sformatf("tv%0d grant", i), 32'(grant), 32'(tv[i].eg));
      chk($sformatf("tv%0d ready", i), 32'(ready), 32'(tv[i].er));
      chk($sformatf("tv%0d wr_en", i), 32'(en), 32'(tv[i].een));
      chk($sformatf("tv%0d wr_data", i), 32'(wdata), 32'(tv[i].ed));
      @(posedge clk); #1;
    end

    // BURST=1 instance: alternation, then a lone requester every cycle
    for (int c = 0; c < 12; c++) begin
      rst1 = (c == 0); v1 = b1_v[c];
      @(negedge clk);
      chk($sformatf("b1 c%0d grant", c), 32'(grant1), 32'(b1_g[c]));
      chk($sformatf("b1 c%0d wr_en", c), 32'(en1), 32'(b1_e[c]));
      if (b1_e[c]) chk($sformatf("b1 c%0d wr_data", c), 32'(wdata1), (b1_g[c] == 4'h1) ? 32'h00 : 32'h11);
      @(posedge clk); #1;
    end
    rst1 = 1'b1; v1 = 4'h0;

    // Back-pressure: req2 alone, 20 words into a 16-deep FIFO with stalled reader
    rst = 1'b1; v = 4'h0; full = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; idx = 0; got = 0;
    for (int c = 0; c < 200 && got < 20; c++) begin
      full = (q.size() >= 16);
      v = (idx < 20) ? 4'h4 : 4'h0;
      d = {8'h00, 8'(8'hA0 + idx), 16'h0000};
      @(negedge clk);
      s_en = en; s_rdy = ready;
      exp_d = wdata;
      if (full) begin
        chk("bp wr_en while full", 32'(en), 32'h0);
        chk("bp ready while full", 32'(ready[2]), 32'h0);
        chk("bp grant while full", 32'(grant), 32'h4);
      end
      @(posedge clk);
      if (s_en) q.push_back(exp_d);
      if (s_rdy[2] && v[2]) idx++;
      if (c >= 40 && q.size() > 0) begin
        popped = q.pop_front();
        chk($sformatf("bp word%0d", got), 32'(popped), 32'(8'hA0 + got));
        got++;
      end
      #1;
    end
    chk("bp words received", 32'(got), 32'd20);

    // Randomized traffic against the reference model
    rst = 1'b1; v = 4'h0; full = 1'b0; d = '0;
    m_own = -1; m_cnt = 0; m_ptr = 0;
    acc = '0;
    for (int c = 0; c < 1500; c++) begin
      if (c > 0) rst = ($urandom_range(0, 199) == 0);
      full = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++) begin
        if (!v[i] || acc[i]) begin
          v[i] = $urandom_range(0, 1) == 1;
          d[i*W +: W] = 8'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          v[i] = 1'b0;
        end
      end
      if (m_own < 0) begin
        exp_g = '0; exp_r = '0; exp_en = 1'b0; exp_d = '0;
      end else begin
        exp_g  = 4'(1 << m_own);
        exp_r  = full ? 4'h0 : exp_g;
        exp_en = v[m_own] && !full;
        exp_d  = 8'(d >> (m_own * W));
      end
      @(negedge clk);
      chk($sformatf("rnd%0d grant", c), 32'(grant), 32'(exp_g));
      chk($sformatf("rnd%0d ready", c), 32'(ready), 32'(exp_r));
      chk($sformatf("rnd%0d wr_en", c), 32'(en), 32'(exp_en));
      chk($sformatf("rnd%0d wr_data", c), 32'(wdata), 32'(exp_d));
      acc = exp_r & v;
      @(posedge clk);
      model_edge();
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
